seq_pattern_tx: RTL

//  Serial pattern transmitter: the stimulus end of the sequence-detection path.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_shift_reg.sv | 65 ++++++
 rtl/seq_pattern_tx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern transmitter and its
// matching sequence detector.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } seq_tx_state_e;

    // Default maximum pattern length in bits.
    localparam int PAT_W_DEFAULT = 8;

    // Bit order on the serial line; the detector side assumes the same order.
    localparam bit MSB_FIRST = 1'b1;

    // Width of a field that holds a length in the range 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable shift register with bit counter. The active window of the pattern
// is aligned on load so the first bit to send sits at the output end; the
// vacated positions fill with zeros, so the output bit falls to 0 on its own
// once the last window bit has been shifted past.
module seq_shift_reg
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int LEN_W = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic [LEN_W-1:0] load_len,
    output logic             serial,
    output logic             last
);

    logic [PAT_W-1:0] data_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [PAT_W-1:0] aligned;
    logic [PAT_W-1:0] load_vec;
    logic [PAT_W-1:0] shifted;

    // Move pattern[len-1] to the MSB; bits above the window fall off the top.
    assign aligned = load_pattern << (LEN_W'(PAT_W) - load_len);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign load_vec = aligned;
            assign shifted  = data_reg << 1;
            assign serial   = data_reg[PAT_W-1];
        end else begin : g_lsb_first
            for (genvar gi = 0; gi < PAT_W; gi++) begin : g_rev
                assign load_vec[gi] = aligned[PAT_W-1-gi];
            end
            assign shifted = data_reg >> 1;
            assign serial  = data_reg[0];
        end
    endgenerate

    // Counter reads 0 while the final bit of the window is on the output.
    assign last = (cnt_reg == '0);

    // Clear beats load beats shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            cnt_reg  <= '0;
        end else if (clear) begin
            data_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            data_reg <= load_vec;
            cnt_reg  <= load_len - LEN_W'(1);
        end else if (shift) begin
            data_reg <= shifted;
            cnt_reg  <= (cnt_reg != '0) ? cnt_reg - LEN_W'(1) : '0;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends the low len bits of a latched pattern,
// first bit = pattern[len-1], reps times with a fixed idle gap between
// copies. All outputs come straight from flops.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEFAULT,
    parameter int REP_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [$clog2(PAT_W+1)-1:0] len,
    input  logic [REP_W-1:0]           reps,
    output logic                       serial_out,
    output logic                       bit_valid,
    output logic                       frame_start,
    output logic                       busy,
    output logic                       done
);

    localparam int LEN_W = len_width(PAT_W);
    // Gap counter counts GAP_CYC-1 down to 0.
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

    seq_tx_state_e    state_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [LEN_W-1:0] len_reg;
    logic [REP_W-1:0] rep_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             bit_valid_reg;
    logic             frame_start_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [LEN_W-1:0] len_clamped;
    logic             more_copies;
    logic             sr_clear;
    logic             sr_load;
    logic             sr_shift;
    logic [PAT_W-1:0] sr_pattern;
    logic [LEN_W-1:0] sr_len;
    logic             sr_serial;
    logic             sr_last;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    // rep_cnt_reg holds the copies still owed, including the one in flight.
    assign more_copies = (rep_cnt_reg > REP_W'(1));

    // Shift-register control: first load comes from the ports, reloads for
    // later copies come from the latched job.
    always_comb begin
        sr_clear   = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_pattern = pat_reg;
        sr_len     = len_reg;
        case (state_reg)
            IDLE: begin
                sr_pattern = pattern;
                sr_len     = len_clamped;
                sr_load    = start && !abort && (len_clamped != '0) && (reps != '0);
            end
            SHIFT: begin
                if (abort) begin
                    sr_clear = 1'b1;
                end else if (sr_last && more_copies && (GAP_CYC == 0)) begin
                    sr_load = 1'b1;
                end else begin
                    sr_shift = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    sr_clear = 1'b1;
                end else if (gap_cnt_reg == '0) begin
                    sr_load = 1'b1;
                end
            end
            default: begin
                sr_clear = abort;
            end
        endcase
    end

    seq_shift_reg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (sr_clear),
        .load         (sr_load),
        .shift        (sr_shift),
        .load_pattern (sr_pattern),
        .load_len     (sr_len),
        .serial       (sr_serial),
        .last         (sr_last)
    );

    // Job sequencing FSM; every flag is registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pat_reg         <= '0;
            len_reg         <= '0;
            rep_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            bit_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        pat_reg     <= pattern;
                        len_reg     <= len_clamped;
                        rep_cnt_reg <= reps;
                        busy_reg    <= 1'b1;
                        if ((len_clamped == '0) || (reps == '0)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg       <= SHIFT;
                            bit_valid_reg   <= 1'b1;
                            frame_start_reg <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        bit_valid_reg <= 1'b0;
                        rep_cnt_reg   <= '0;
                        gap_cnt_reg   <= '0;
                    end else if (sr_last) begin
                        if (more_copies) begin
                            rep_cnt_reg <= rep_cnt_reg - REP_W'(1);
                            if (GAP_CYC > 0) begin
                                state_reg     <= GAP;
                                gap_cnt_reg   <= GAP_LOAD;
                                bit_valid_reg <= 1'b0;
                            end else begin
                                frame_start_reg <= 1'b1;
                            end
                        end else begin
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            bit_valid_reg <= 1'b0;
                            rep_cnt_reg   <= '0;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        rep_cnt_reg <= '0;
                        gap_cnt_reg <= '0;
                    end else if (gap_cnt_reg == '0) begin
                        state_reg       <= SHIFT;
                        bit_valid_reg   <= 1'b1;
                        frame_start_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    bit_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out  = sr_serial;
    assign bit_valid   = bit_valid_reg;
    assign frame_start = frame_start_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule
